load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer for a single-port word memory with one-cycle read latency.
// Sub-word stores use read-modify-write; faulting requests finish without touching memory.
module load_store_unit #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic        IsStore,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ByteAddr,
  input  logic [31:0] StoreData,
  input  logic [31:0] MemReadData,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemW,
  output logic [31:0] LoadData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t      state_reg, state_next;
  logic        is_store_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] sdata_reg;
  logic [31:0] load_data_reg;
  logic [31:0] merged_reg;
  logic        fault_reg;

  logic        req_fault;
  logic [31:0] word_idx;
  logic [7:0]  rd_lane [4];
  logic [3:0]  lane_en;
  logic        store_half;
  logic [31:0] merged_next;
  logic [31:0] load_next;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign word_idx = {2'b00, ByteAddr[31:2]};

  // Fault classification of the incoming request, evaluated only when accepted in IDLE.
  always_comb begin
    req_fault = 1'b0;
    case (Funct3)
      3'd0:       req_fault = 1'b0;
      3'd1:       req_fault = ByteAddr[0];
      3'd2:       req_fault = (ByteAddr[1:0] != 2'b00);
      3'd4, 3'd5: req_fault = IsStore || (Funct3[0] && ByteAddr[0]);
      default:    req_fault = 1'b1;
    endcase
    if (word_idx >= 32'(MEM_DEPTH)) begin
      req_fault = 1'b1;
    end
  end

  assign store_half = (funct3_reg[1:0] == 2'd1);

  // Per-lane read split and store merge; half stores put StoreData[15:8] in the odd lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] src;
      assign rd_lane[gi] = MemReadData[8*gi +: 8];
      assign lane_en[gi] = store_half ? (addr_reg[1] == 1'(gi / 2))
                                      : (addr_reg[1:0] == 2'(gi));
      assign src = (store_half && ((gi % 2) == 1)) ? sdata_reg[15:8] : sdata_reg[7:0];
      assign merged_next[8*gi +: 8] = lane_en[gi] ? src : rd_lane[gi];
    end
  endgenerate

  assign load_byte = rd_lane[addr_reg[1:0]];
  assign load_half = {rd_lane[{addr_reg[1], 1'b1}], rd_lane[{addr_reg[1], 1'b0}]};

  always_comb begin
    load_next = MemReadData;
    case (funct3_reg)
      3'd0:    load_next = {{24{load_byte[7]}}, load_byte};
      3'd1:    load_next = {{16{load_half[15]}}, load_half};
      3'd4:    load_next = {24'h000000, load_byte};
      3'd5:    load_next = {16'h0000, load_half};
      default: load_next = MemReadData;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          if (req_fault) begin
            state_next = DONE;
          end else if (IsStore && (Funct3 == 3'd2)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = is_store_reg ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      is_store_reg  <= 1'b0;
      funct3_reg    <= 3'd0;
      addr_reg      <= 32'd0;
      sdata_reg     <= 32'd0;
      load_data_reg <= 32'd0;
      merged_reg    <= 32'd0;
      fault_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            is_store_reg <= IsStore;
            funct3_reg   <= Funct3;
            addr_reg     <= ByteAddr;
            sdata_reg    <= StoreData;
            fault_reg    <= req_fault;
          end
        end
        CAP: begin
          if (is_store_reg) begin
            merged_reg <= merged_next;
          end else begin
            load_data_reg <= load_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Control outputs are gated by RST so an abort in WR never commits a write.
  assign MemAddress   = {2'b00, addr_reg[31:2]};
  assign MemWriteData = (funct3_reg == 3'd2) ? sdata_reg : merged_reg;
  assign MemW         = (state_reg == WR) && !RST;
  assign LoadData     = load_data_reg;
  assign Busy         = (state_reg != IDLE) && !RST;
  assign Done         = (state_reg == DONE) && !RST;
  assign Fault        = fault_reg && !RST;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural one-cycle-latency word memory.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic        IsStore = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] ByteAddr = 32'd0;
  logic [31:0] StoreData = 32'd0;
  logic [31:0] MemReadData;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemW;
  logic [31:0] LoadData;
  logic        Busy;
  logic        Done;
  logic        Fault;

  int checks = 0;
  int errors = 0;
  int memw_count = 0;
  int done_count = 0;

  logic [31:0] ram [0:1023];
  logic [9:0]  ram_idx;

  always #5 CLK = ~CLK;

  load_store_unit #(.MEM_DEPTH(1024)) dut (
    .CLK(CLK),
    .RST(RST),
    .Start(Start),
    .IsStore(IsStore),
    .Funct3(Funct3),
    .ByteAddr(ByteAddr),
    .StoreData(StoreData),
    .MemReadData(MemReadData),
    .MemAddress(MemAddress),
    .MemWriteData(MemWriteData),
    .MemW(MemW),
    .LoadData(LoadData),
    .Busy(Busy),
    .Done(Done),
    .Fault(Fault)
  );

  assign ram_idx = MemAddress[9:0];

  always @(posedge CLK) begin
    MemReadData <= ram[ram_idx];
    if (MemW === 1'b1) begin
      ram[ram_idx] <= MemWriteData;
      memw_count++;
    end
    if (Done === 1'b1) begin
      done_count++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: Start is driven in an IDLE cycle; cycles counts edges from the Start edge to Done.
  task automatic req(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] sd, input int exp_cyc,
                     input logic exp_fault, input logic [31:0] exp_load, input bit hold);
    int n;
    @(posedge CLK); #1;
    chk({tag, ":idle_done"}, 32'(Done), 32'd0);
    chk({tag, ":idle_busy"}, 32'(Busy), 32'd0);
    memw_count = 0;
    Start = 1'b1; IsStore = st; Funct3 = f3; ByteAddr = addr; StoreData = sd;
    @(posedge CLK); #1;
    if (hold) begin
      IsStore = 1'b1; Funct3 = 3'd2; ByteAddr = 32'h14; StoreData = 32'hDEADBEEF;
    end else begin
      Start = 1'b0;
    end
    chk({tag, ":busy"}, 32'(Busy), 32'd1);
    chk({tag, ":addr"}, MemAddress, {2'b00, addr[31:2]});
    chk({tag, ":fault_early"}, 32'(Fault), 32'(exp_fault));
    n = 1;
    while (Done !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    Start = 1'b0;
    chk({tag, ":cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, ":fault"}, 32'(Fault), 32'(exp_fault));
    chk({tag, ":load"}, LoadData, exp_load);
    chk({tag, ":memw"}, 32'(memw_count), (st && !exp_fault) ? 32'd1 : 32'd0);
    $display("txn %s store=%b f3=%0d addr=%h cycles=%0d load=%h fault=%b",
             tag, st, f3, addr, n, LoadData, Fault);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    ram[4] = 32'h8765F0A1;

    // Reset with a Start present must stay idle with every output low.
    Start = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset:ctl", {28'd0, Busy, Done, MemW, Fault}, 32'd0);
    chk("reset:load", LoadData, 32'd0);
    chk("reset:addr", MemAddress, 32'd0);
    chk("reset:wdata", MemWriteData, 32'd0);
    Start = 1'b0;
    RST = 1'b0;

    req("lb",  1'b0, 3'd0, 32'h10, 32'h0, 3, 1'b0, 32'hFFFFFFA1, 1'b0);
    req("lbu", 1'b0, 3'd4, 32'h11, 32'h0, 3, 1'b0, 32'h000000F0, 1'b0);
    req("lh",  1'b0, 3'd1, 32'h12, 32'h0, 3, 1'b0, 32'hFFFF8765, 1'b0);
    req("lhu_hold", 1'b0, 3'd5, 32'h12, 32'h0, 3, 1'b0, 32'h00008765, 1'b1);
    req("sb",  1'b1, 3'd0, 32'h13, 32'h000000CC, 4, 1'b0, 32'h00008765, 1'b0);
    chk("sb:ram4", ram[4], 32'hCC65F0A1);
    req("lw",  1'b0, 3'd2, 32'h10, 32'h0, 3, 1'b0, 32'hCC65F0A1, 1'b0);
    req("sw",  1'b1, 3'd2, 32'h14, 32'h12345678, 2, 1'b0, 32'hCC65F0A1, 1'b0);
    chk("sw:ram5", ram[5], 32'h12345678);
    req("lw_mis", 1'b0, 3'd2, 32'h12, 32'h0, 1, 1'b1, 32'hCC65F0A1, 1'b0);
    req("lb_oob", 1'b0, 3'd0, 32'h1000, 32'h0, 1, 1'b1, 32'hCC65F0A1, 1'b0);
    req("sh_odd", 1'b1, 3'd1, 32'h11, 32'h0000FFFF, 1, 1'b1, 32'hCC65F0A1, 1'b0);
    req("sbu_bad", 1'b1, 3'd4, 32'h10, 32'h0000FFFF, 1, 1'b1, 32'hCC65F0A1, 1'b0);
    req("f3_7", 1'b0, 3'd7, 32'h10, 32'h0, 1, 1'b1, 32'hCC65F0A1, 1'b0);
    chk("fault:ram4", ram[4], 32'hCC65F0A1);
    req("lbu_b3", 1'b0, 3'd4, 32'h17, 32'h0, 3, 1'b0, 32'h00000012, 1'b0);

    // SH aborted by reset asserted during the WR cycle.
    @(posedge CLK); #1;
    Start = 1'b1; IsStore = 1'b1; Funct3 = 3'd1; ByteAddr = 32'h10; StoreData = 32'h0000BEEF;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("abort:wr_memw", 32'(MemW), 32'd1);
    chk("abort:wr_data", MemWriteData, 32'hCC65BEEF);
    RST = 1'b1;
    #1;
    chk("abort:memw_gated", 32'(MemW), 32'd0);
    @(posedge CLK); #1;
    chk("abort:ctl", {28'd0, Busy, Done, MemW, Fault}, 32'd0);
    chk("abort:load", LoadData, 32'd0);
    chk("abort:addr", MemAddress, 32'd0);
    chk("abort:wdata", MemWriteData, 32'd0);
    chk("abort:ram4", ram[4], 32'hCC65F0A1);
    RST = 1'b0;
    done_count = 0;
    repeat (4) @(posedge CLK);
    #1;
    chk("abort:no_done", 32'(done_count), 32'd0);

    req("sh_hi", 1'b1, 3'd1, 32'h12, 32'h00001234, 4, 1'b0, 32'h0, 1'b0);
    chk("sh_hi:ram4", ram[4], 32'h1234F0A1);
    req("lh_lo", 1'b0, 3'd1, 32'h10, 32'h0, 3, 1'b0, 32'hFFFFF0A1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
